gpio_disp_evt_ctrl: RTL and testbench



---
 rtl/gpio_disp_evt_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gpio_disp_evt_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_disp_evt_ctrl.sv
// gpio_disp_evt_ctrl: shares the GPIO bus between the CPU and two engines.
//   Display engine: writes active-low 7-segment codes of a 32-bit value to HEX0..HEX(DIGITS-1).
//   Event engine: on GPIO Intr (active-low), reads KEY then SW status and presents them on valid/ready.
// The CPU always wins the bus; an engine access stalls until the CPU releases cs_n.
// Optional: define GPIO_CTRL_BLANK_EN to blank leading zero digits (digit 0 always shown).
module gpio_disp_evt_ctrl #(
    parameter logic [11:0] KEY_ADDR  = 12'h000,
    parameter logic [11:0] SW_ADDR   = 12'h004,
    parameter logic [11:0] HEX0_ADDR = 12'h010,
    parameter int unsigned DIGITS    = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_cs_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        disp_valid,
    input  logic [31:0] disp_value,
    output logic        disp_ready,
    input  logic        gpio_intr,
    output logic        evt_valid,
    output logic [3:0]  evt_key,
    output logic [17:0] evt_sw,
    input  logic        evt_ready,
    output logic        gpio_cs_n,
    output logic        gpio_rd_n,
    output logic        gpio_wr_n,
    output logic [11:0] gpio_addr,
    output logic [31:0] gpio_wdata,
    input  logic [31:0] gpio_rdata
);

    localparam logic [2:0] LAST = 3'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, HEX_WR, KEY_RD, SW_RD, EVT_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_value;
    logic [3:0]  r_evt_key;
    logic [17:0] r_evt_sw;

    logic        w_cpu_act;
    logic        w_ld, w_inc, w_cap_key, w_cap_sw;
    logic        w_eng_cs_n, w_eng_rd_n, w_eng_wr_n;
    logic [11:0] w_eng_addr;
    logic [31:0] w_eng_wdata;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic [6:0]  w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign w_cpu_act = ~cpu_cs_n;
    assign w_nib     = r_value[{r_cnt, 2'b00} +: 4];

`ifdef GPIO_CTRL_BLANK_EN
    logic [2:0] w_msd;

    // Index of the most significant nonzero nibble; digits above it are blanked.
    always_comb begin
        w_msd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r_value[4*i +: 4] != 4'h0) w_msd = 3'(i);
        end
    end
    assign w_blank = (r_cnt > w_msd);
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg = w_blank ? 7'h7F : seg7(w_nib);

    // State register, digit counter, latched display value and captured event data.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_value   <= '0;
            r_evt_key <= '0;
            r_evt_sw  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld) begin
                r_value <= disp_value;
                r_cnt   <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_cap_key) r_evt_key <= gpio_rdata[3:0];
            if (w_cap_sw)  r_evt_sw  <= gpio_rdata[17:0];
        end
    end

    // Next-state and engine bus request; bus states only advance on a cycle the CPU leaves free.
    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_inc       = 1'b0;
        w_cap_key   = 1'b0;
        w_cap_sw    = 1'b0;
        w_eng_cs_n  = 1'b1;
        w_eng_rd_n  = 1'b1;
        w_eng_wr_n  = 1'b1;
        w_eng_addr  = '0;
        w_eng_wdata = '0;
        case (r_state)
            IDLE: begin
                if (!gpio_intr) begin
                    w_state_nxt = KEY_RD;
                end else if (disp_valid) begin
                    w_ld        = 1'b1;
                    w_state_nxt = HEX_WR;
                end
            end
            HEX_WR: begin
                w_eng_cs_n  = 1'b0;
                w_eng_wr_n  = 1'b0;
                w_eng_addr  = HEX0_ADDR + 12'({r_cnt, 2'b00});
                w_eng_wdata = {25'b0, w_seg};
                if (!w_cpu_act) begin
                    w_inc = 1'b1;
                    if (r_cnt == LAST) w_state_nxt = IDLE;
                end
            end
            KEY_RD: begin
                w_eng_cs_n = 1'b0;
                w_eng_rd_n = 1'b0;
                w_eng_addr = KEY_ADDR;
                if (!w_cpu_act) begin
                    w_cap_key   = 1'b1;
                    w_state_nxt = SW_RD;
                end
            end
            SW_RD: begin
                w_eng_cs_n = 1'b0;
                w_eng_rd_n = 1'b0;
                w_eng_addr = SW_ADDR;
                if (!w_cpu_act) begin
                    w_cap_sw    = 1'b1;
                    w_state_nxt = EVT_HOLD;
                end
            end
            EVT_HOLD: begin
                if (evt_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign gpio_cs_n  = w_cpu_act ? cpu_cs_n  : w_eng_cs_n;
    assign gpio_rd_n  = w_cpu_act ? cpu_rd_n  : w_eng_rd_n;
    assign gpio_wr_n  = w_cpu_act ? cpu_wr_n  : w_eng_wr_n;
    assign gpio_addr  = w_cpu_act ? cpu_addr  : w_eng_addr;
    assign gpio_wdata = w_cpu_act ? cpu_wdata : w_eng_wdata;
    assign cpu_rdata  = w_cpu_act ? gpio_rdata : '0;

    assign disp_ready = (r_state == IDLE) & gpio_intr;
    assign evt_valid  = (r_state == EVT_HOLD);
    assign evt_key    = r_evt_key;
    assign evt_sw     = r_evt_sw;

endmodule

// File: tb/tb_gpio_disp_evt_ctrl.sv
// Directed bench for gpio_disp_evt_ctrl with a small clear-on-read GPIO status model.
module tb_gpio_disp_evt_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cpu_cs_n, cpu_rd_n, cpu_wr_n;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        disp_valid, disp_ready;
    logic [31:0] disp_value;
    logic        gpio_intr;
    logic        evt_valid, evt_ready;
    logic [3:0]  evt_key;
    logic [17:0] evt_sw;
    logic        gpio_cs_n, gpio_rd_n, gpio_wr_n;
    logic [11:0] gpio_addr;
    logic [31:0] gpio_wdata, gpio_rdata;

    // GPIO status model: loadable KEY/SW registers, cleared by any read strobe at their address.
    logic [3:0]  key_reg = '0;
    logic [17:0] sw_reg  = '0;
    logic        load_en = 1'b0;
    logic [3:0]  load_key = '0;
    logic [17:0] load_sw  = '0;

    int n_chk  = 0;
    int n_fail = 0;

    gpio_disp_evt_ctrl #(
        .KEY_ADDR(12'h000), .SW_ADDR(12'h004), .HEX0_ADDR(12'h010), .DIGITS(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .disp_valid(disp_valid), .disp_value(disp_value), .disp_ready(disp_ready),
        .gpio_intr(gpio_intr), .evt_valid(evt_valid), .evt_key(evt_key), .evt_sw(evt_sw),
        .evt_ready(evt_ready),
        .gpio_cs_n(gpio_cs_n), .gpio_rd_n(gpio_rd_n), .gpio_wr_n(gpio_wr_n),
        .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (load_en) begin
            key_reg <= load_key;
            sw_reg  <= load_sw;
        end else if (!gpio_cs_n && !gpio_rd_n) begin
            if (gpio_addr == 12'h000) key_reg <= '0;
            if (gpio_addr == 12'h004) sw_reg  <= '0;
        end
    end

    assign gpio_intr  = ~((|key_reg) | (|sw_reg));
    assign gpio_rdata = (gpio_addr == 12'h000) ? {28'b0, key_reg} :
                        (gpio_addr == 12'h004) ? {14'b0, sw_reg}  :
                        (gpio_addr == 12'h008) ? 32'h0000_CAFE    : '0;

    typedef struct {
        logic [31:0]      value;
        logic [7:0][6:0]  plain;   // digit 7 .. digit 0
        logic [7:0][6:0]  blank;
    } dvec_t;

    dvec_t vecs [5];

    task automatic step();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_status(input logic [3:0] k, input logic [17:0] s);
        load_key = k;
        load_sw  = s;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic run_disp(input int idx, input logic [31:0] v, input logic [7:0][6:0] exp);
        disp_valid = 1'b1;
        disp_value = v;
        #1 chk($sformatf("v%0d ready_in", idx), {31'b0, disp_ready}, 32'd1);
        step();
        disp_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("v%0d d%0d strobes", idx, i), {29'b0, gpio_cs_n, gpio_rd_n, gpio_wr_n}, 32'b010);
            chk($sformatf("v%0d d%0d addr", idx, i), {20'b0, gpio_addr}, 32'h10 + 32'(4 * i));
            chk($sformatf("v%0d d%0d data", idx, i), gpio_wdata, {25'b0, exp[i]});
            step();
        end
        #1;
        chk($sformatf("v%0d ready_out", idx), {31'b0, disp_ready}, 32'd1);
        chk($sformatf("v%0d bus_idle", idx), {31'b0, gpio_cs_n}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{value: 32'h0000_1234,
                    plain: {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19},
                    blank: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{value: 32'h89AB_CDEF,
                    plain: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    blank: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[2] = '{value: 32'h0000_00A0,
                    plain: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40},
                    blank: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[3] = '{value: 32'h0000_0000,
                    plain: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    blank: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{value: 32'h7650_0000,
                    plain: {7'h78, 7'h02, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    blank: {7'h78, 7'h02, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        reset = 1'b1;
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_addr = '0; cpu_wdata = '0;
        disp_valid = 1'b0; disp_value = '0; evt_ready = 1'b0;
        step();
        step();
        #1;
        chk("rst strobes", {29'b0, gpio_cs_n, gpio_rd_n, gpio_wr_n}, 32'b111);
        chk("rst addr", {20'b0, gpio_addr}, 32'h0);
        chk("rst wdata", gpio_wdata, 32'h0);
        chk("rst evt", {9'b0, evt_valid, evt_key, evt_sw}, 32'h0);
        chk("rst ready", {31'b0, disp_ready}, 32'd1);
        chk("rst cpu_rdata", cpu_rdata, 32'h0);
        reset = 1'b0;
        step();

        // Display vectors
        for (int v = 0; v < 5; v++) begin
`ifdef GPIO_CTRL_BLANK_EN
            run_disp(v, vecs[v].value, vecs[v].blank);
`else
            run_disp(v, vecs[v].value, vecs[v].plain);
`endif
            step();
        end

        // CPU write steals the bus during digit 2
        disp_valid = 1'b1;
        disp_value = 32'h0000_1234;
        step();
        disp_valid = 1'b0;
        step();
        step();
        cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 12'h008; cpu_wdata = 32'h3;
        #1;
        chk("cpu strobes", {29'b0, gpio_cs_n, gpio_rd_n, gpio_wr_n}, 32'b010);
        chk("cpu addr", {20'b0, gpio_addr}, 32'h008);
        chk("cpu wdata", gpio_wdata, 32'h3);
        step();
        cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 2; i < 8; i++) begin
            #1;
            chk($sformatf("stall d%0d addr", i), {20'b0, gpio_addr}, 32'h10 + 32'(4 * i));
            chk($sformatf("stall d%0d wr_n", i), {31'b0, gpio_wr_n}, 32'd0);
            if (i == 2) chk("stall d2 data", gpio_wdata, 32'h24);
            step();
        end
        #1 chk("stall end ready", {31'b0, disp_ready}, 32'd1);

        // Event: KEY=2, SW=5, consumer holds off for 5 cycles
        load_status(4'h2, 18'h00005);
        #1 chk("evtA ready_low", {31'b0, disp_ready}, 32'd0);
        step();
        #1;
        chk("evtA key strobes", {29'b0, gpio_cs_n, gpio_rd_n, gpio_wr_n}, 32'b001);
        chk("evtA key addr", {20'b0, gpio_addr}, 32'h000);
        chk("evtA cpu_rdata gated", cpu_rdata, 32'h0);
        step();
        #1;
        chk("evtA sw strobes", {29'b0, gpio_cs_n, gpio_rd_n, gpio_wr_n}, 32'b001);
        chk("evtA sw addr", {20'b0, gpio_addr}, 32'h004);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("evtA hold%0d valid", i), {31'b0, evt_valid}, 32'd1);
            chk($sformatf("evtA hold%0d key", i), {28'b0, evt_key}, 32'h2);
            chk($sformatf("evtA hold%0d sw", i), {14'b0, evt_sw}, 32'h5);
            step();
        end
        evt_ready = 1'b1;
        #1 chk("evtA valid_at_ready", {31'b0, evt_valid}, 32'd1);
        step();
        evt_ready = 1'b0;
        #1;
        chk("evtA valid_clr", {31'b0, evt_valid}, 32'd0);
        chk("evtA idle ready", {31'b0, disp_ready}, 32'd1);

        // Event with a CPU read stalling KEY_RD
        load_status(4'h4, 18'h3FFFF);
        step();
        cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 12'h008;
        #1;
        chk("evtB cpu addr", {20'b0, gpio_addr}, 32'h008);
        chk("evtB cpu_rdata", cpu_rdata, 32'h0000_CAFE);
        step();
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; cpu_addr = '0;
        #1 chk("evtB key retry addr", {20'b0, gpio_addr, 1'b0, gpio_rd_n} >> 2, 32'h0);
        chk("evtB key retry rd_n", {31'b0, gpio_rd_n}, 32'd0);
        step();
        #1 chk("evtB sw addr", {20'b0, gpio_addr}, 32'h004);
        step();
        #1;
        chk("evtB key", {28'b0, evt_key}, 32'h4);
        chk("evtB sw", {14'b0, evt_sw}, 32'h3FFFF);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        #1 chk("evtB valid_clr", {31'b0, evt_valid}, 32'd0);

        // Simultaneous display request and interrupt: event first
        load_status(4'h1, 18'h0);
        disp_valid = 1'b1;
        disp_value = 32'h0000_1234;
        #1 chk("prio ready_low", {31'b0, disp_ready}, 32'd0);
        step();
        #1 chk("prio key_rd", {19'b0, gpio_addr, gpio_rd_n}, 32'h0);
        step();
        step();
        #1;
        chk("prio hold valid", {31'b0, evt_valid}, 32'd1);
        chk("prio hold ready_low", {31'b0, disp_ready}, 32'd0);
        chk("prio key", {28'b0, evt_key}, 32'h1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        #1 chk("prio idle ready", {31'b0, disp_ready}, 32'd1);
        step();
        disp_valid = 1'b0;
        #1;
        chk("prio d0 addr", {20'b0, gpio_addr}, 32'h010);
        chk("prio d0 data", gpio_wdata, 32'h19);
        for (int i = 0; i < 8; i++) step();
        #1 chk("prio disp done", {31'b0, disp_ready}, 32'd1);

        // Reset while digit 5 is on the bus
        disp_valid = 1'b1;
        disp_value = 32'h0000_1234;
        step();
        disp_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1 chk("rstmid d5 addr", {20'b0, gpio_addr}, 32'h024);
        reset = 1'b1;
        step();
        #1;
        chk("rstmid cs_n", {31'b0, gpio_cs_n}, 32'd1);
        chk("rstmid evt", {9'b0, evt_valid, evt_key, evt_sw}, 32'h0);
        chk("rstmid ready", {31'b0, disp_ready}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1 chk($sformatf("rstmid quiet%0d", i), {31'b0, gpio_cs_n}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
